// File: rtl/l0_skew_feeder_pkg.sv
// ---------------------------------------------------------------------------
// l0_skew_feeder_pkg
//   Constants and types shared by the L0 skew feeder, the systolic array and
//   the MAC tiles.
//   - ROW_DEFAULT / BW_DEFAULT / DEPTH_DEFAULT : default array geometry
//   - inst_e : 2-bit west instruction (bit1 = execute, bit0 = kernel load)
//   - ptr_width() : FIFO pointer width, one wrap bit above the address bits
// ---------------------------------------------------------------------------
package l0_skew_feeder_pkg;

    localparam int unsigned ROW_DEFAULT   = 8;
    localparam int unsigned BW_DEFAULT    = 4;
    localparam int unsigned DEPTH_DEFAULT = 64;

    typedef enum logic [1:0] {
        INST_IDLE = 2'b00,
        INST_LOAD = 2'b01,
        INST_EXEC = 2'b10
    } inst_e;

    // Address bits plus one wrap bit so full and empty can be told apart.
    function automatic int unsigned ptr_width(input int unsigned entries);
        return $clog2(entries) + 1;
    endfunction

endpackage

// File: rtl/l0_skew_feeder_row_fifo.sv
// ---------------------------------------------------------------------------
// l0_row_fifo
//   One lane of the L0 buffer: depth x bw storage plus read/write pointers.
//   Ports:
//     clk    : clock, rising edge
//     reset  : asynchronous active-low reset (pointers only)
//     push   : write din this cycle (ignored when full)
//     pop    : advance the read pointer this cycle (ignored when empty)
//     din    : write data
//     dout   : entry at the read pointer (valid when !empty)
//     full   : depth entries held
//     empty  : no entries held
//   Pointers are ptr_width(depth) bits and wrap modulo 2*depth; storage is
//   not reset because the pointers alone define which entries are live.
// ---------------------------------------------------------------------------
module l0_row_fifo
    import l0_skew_feeder_pkg::*;
#(
    parameter int unsigned bw    = BW_DEFAULT,
    parameter int unsigned depth = DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [bw-1:0] din,
    output logic [bw-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int unsigned PW = ptr_width(depth);
    localparam int unsigned AW = PW - 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [bw-1:0] mem_q [depth];
    logic          do_push;
    logic          do_pop;

    always_comb begin
        // Wrap bits differ with equal address bits: writer is a full lap ahead.
        full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty   = (wr_ptr_q == rd_ptr_q);
        do_push = push && !full;
        do_pop  = pop && !empty;
        dout    = mem_q[rd_ptr_q[AW-1:0]];

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/l0_skew_feeder.sv
// ---------------------------------------------------------------------------
// l0_skew_feeder
//   L0 activation/weight buffer feeding the west edge of a systolic array.
//   Each array row has its own FIFO lane; a read request is delayed by r
//   cycles for lane r so the array sees a diagonal wavefront.
//   Ports:
//     clk      : clock, rising edge
//     reset    : asynchronous active-low reset
//     in       : write vector, lane r at [r*bw +: bw]
//     wr       : push in into every lane (dropped while o_full)
//     rd       : start a skewed read of one vector
//     inst_in  : instruction travelling with the read (bit1 exec, bit0 load)
//     out      : per-lane west data, 0 in cycles without a pop on that lane
//     inst_out : per-lane west instruction, 2'b00 without a pop
//     o_full   : some lane holds depth entries
//     o_ready  : !o_full
//     o_valid  : lane 0 holds at least one entry
//   Timing: rd accepted in cycle t pops lane r at the end of cycle t+r and
//   presents the entry on out/inst_out lane r during cycle t+1+r.
// ---------------------------------------------------------------------------
module l0_skew_feeder
    import l0_skew_feeder_pkg::*;
#(
    parameter int unsigned row   = ROW_DEFAULT,
    parameter int unsigned bw    = BW_DEFAULT,
    parameter int unsigned depth = DEPTH_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [row*bw-1:0]   in,
    input  logic                wr,
    input  logic                rd,
    input  logic [1:0]          inst_in,
    output logic [row*bw-1:0]   out,
    output logic [row*2-1:0]    inst_out,
    output logic                o_full,
    output logic                o_ready,
    output logic                o_valid
);

    // Lane 0 uses rd directly; lanes 1..row-1 take stage r-1 of the delay line.
    localparam int unsigned SKEW = (row > 1) ? row - 1 : 1;

    logic [SKEW-1:0]     rd_skew_q, rd_skew_d;
    logic [1:0]          inst_skew_q [SKEW];
    logic [1:0]          inst_skew_d [SKEW];

    logic [row-1:0]      lane_rd;
    logic [row-1:0]      lane_pop;
    logic [row-1:0]      lane_full;
    logic [row-1:0]      lane_empty;
    logic [1:0]          lane_inst [row];
    logic [bw-1:0]       lane_head [row];
    logic                push;

    logic [row*bw-1:0]   out_q, out_d;
    logic [row*2-1:0]    inst_out_q, inst_out_d;

    // Status flags come straight from the registered pointers.
    always_comb begin
        o_full  = |lane_full;
        o_ready = !o_full;
        o_valid = !lane_empty[0];
        // One shared push: a write lands in every lane or in none.
        push    = wr && !o_full;
    end

    // Per-lane read request and instruction, then the next delay-line state.
    always_comb begin
        lane_rd      = '0;
        lane_rd[0]   = rd;
        lane_inst[0] = rd ? inst_in : INST_IDLE;
        for (int unsigned r = 1; r < row; r++) begin
            lane_rd[r]   = rd_skew_q[r-1];
            lane_inst[r] = inst_skew_q[r-1];
        end

        rd_skew_d      = '0;
        rd_skew_d[0]   = lane_rd[0];
        inst_skew_d[0] = lane_inst[0];
        for (int unsigned k = 1; k < SKEW; k++) begin
            rd_skew_d[k]   = rd_skew_q[k-1];
            inst_skew_d[k] = inst_skew_q[k-1];
        end
    end

    // A request reaching an empty lane becomes a bubble and leaves the lane alone.
    always_comb begin
        lane_pop   = lane_rd & ~lane_empty;
        out_d      = '0;
        inst_out_d = '0;
        for (int unsigned r = 0; r < row; r++) begin
            if (lane_pop[r]) begin
                out_d[r*bw +: bw]   = lane_head[r];
                inst_out_d[r*2 +: 2] = lane_inst[r];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_skew_q  <= '0;
            out_q      <= '0;
            inst_out_q <= '0;
            for (int unsigned k = 0; k < SKEW; k++) begin
                inst_skew_q[k] <= '0;
            end
        end else begin
            rd_skew_q  <= rd_skew_d;
            out_q      <= out_d;
            inst_out_q <= inst_out_d;
            for (int unsigned k = 0; k < SKEW; k++) begin
                inst_skew_q[k] <= inst_skew_d[k];
            end
        end
    end

    always_comb begin
        out      = out_q;
        inst_out = inst_out_q;
    end

    for (genvar g = 0; g < row; g++) begin : g_lane
        l0_row_fifo #(
            .bw    (bw),
            .depth (depth)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .push  (push),
            .pop   (lane_pop[g]),
            .din   (in[g*bw +: bw]),
            .dout  (lane_head[g]),
            .full  (lane_full[g]),
            .empty (lane_empty[g])
        );
    end

endmodule
